mem_ctrl: RTL and testbench

Memory-side responder for the cache/memory arbiter. It accepts line-wide read and write requests, tagged with the arbiter's transaction id, and acknowledges each one in the cycle it is taken. It services each request against an internal line array. Read data returns in request order after a fixed latency, tagged with the originating id, and holds under a valid/ack handshake until the arbiter consumes it.

---
 rtl/mem_ctrl_if.sv | 40 ++++
 rtl/mem_ctrl.sv | 104 ++++++++++
 tb/tb_mem_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// ============================================================================
// Module      : mem_ctrl_if
// Description : Request/response bundle between the arbiter (master) and the
//               memory responder (slave).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_ctrl_if #(
  parameter int PA_WIDTH   = 8,
  parameter int LINE_WIDTH = 16,
  parameter int ID_WIDTH   = 3
);
  logic                  i_req_enable;
  logic [PA_WIDTH-1:0]   i_req_addr;
  logic [LINE_WIDTH-1:0] i_req_data;
  logic                  i_req_write;
  logic [ID_WIDTH-1:0]   i_req_id;
  logic                  o_req_ack;
  logic                  o_resp_enable;
  logic [ID_WIDTH-1:0]   o_resp_id;
  logic [LINE_WIDTH-1:0] o_resp_data;
  logic                  i_resp_ack;

  modport master (
    output i_req_enable, i_req_addr, i_req_data, i_req_write, i_req_id,
    input  o_req_ack,
    input  o_resp_enable, o_resp_id, o_resp_data,
    output i_resp_ack
  );

  modport slave (
    input  i_req_enable, i_req_addr, i_req_data, i_req_write, i_req_id,
    output o_req_ack,
    output o_resp_enable, o_resp_id, o_resp_data,
    input  i_resp_ack
  );
endinterface

`default_nettype wire

// File: rtl/mem_ctrl.sv
// ============================================================================
// Module      : mem_ctrl
// Description : Line-array memory responder with an in-order, fixed-latency
//               response queue. Optional macro MEM_CTRL_WRITE_RESP_EN makes
//               writes queue a response too.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_ctrl #(
  parameter int PA_WIDTH    = 8,
  parameter int LINE_WIDTH  = 16,
  parameter int ID_WIDTH    = 3,
  parameter int QUEUE_DEPTH = 4,
  parameter int LATENCY     = 3
) (
  input  wire logic   clk,
  input  wire logic   rst,
  mem_ctrl_if.slave   bus
);
  localparam int c_PTR_W = $clog2(QUEUE_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_CD_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(QUEUE_DEPTH);
  localparam logic [c_CD_W-1:0]  c_CD_INIT = c_CD_W'(LATENCY - 1);

  logic [LINE_WIDTH-1:0] r_mem    [2**PA_WIDTH];
  logic [ID_WIDTH-1:0]   r_q_id   [QUEUE_DEPTH];
  logic [LINE_WIDTH-1:0] r_q_data [QUEUE_DEPTH];
  logic [c_CD_W-1:0]     r_q_cd   [QUEUE_DEPTH];
  logic [c_PTR_W-1:0]    r_rd_ptr;
  logic [c_PTR_W-1:0]    r_wr_ptr;
  logic [c_CNT_W-1:0]    r_count;

  logic                  w_has_room;
  logic                  w_req_ack;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_resp_en;
  logic [LINE_WIDTH-1:0] w_push_data;

  // Room is judged on registered count only, so a pop in the same cycle
  // never opens a slot for the request being offered.
  assign w_has_room = (r_count < c_DEPTH);

`ifdef MEM_CTRL_WRITE_RESP_EN
  assign w_req_ack = rst && bus.i_req_enable && w_has_room;
  assign w_push    = w_req_ack;
`else
  assign w_req_ack = rst && bus.i_req_enable && (bus.i_req_write || w_has_room);
  assign w_push    = w_req_ack && !bus.i_req_write;
`endif

  assign w_push_data = bus.i_req_write ? bus.i_req_data : r_mem[bus.i_req_addr];
  assign w_resp_en   = (r_count != '0) && (r_q_cd[r_rd_ptr] == '0);
  assign w_pop       = w_resp_en && bus.i_resp_ack;

  assign bus.o_req_ack     = w_req_ack;
  assign bus.o_resp_enable = w_resp_en;
  assign bus.o_resp_id     = r_q_id[r_rd_ptr];
  assign bus.o_resp_data   = r_q_data[r_rd_ptr];

  // Line array deliberately has no reset so its contents survive rst.
  always_ff @(posedge clk) begin
    if (w_req_ack && bus.i_req_write) begin
      r_mem[bus.i_req_addr] <= bus.i_req_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        r_q_id[i]   <= '0;
        r_q_data[i] <= '0;
        r_q_cd[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (r_q_cd[i] != '0) begin
          r_q_cd[i] <= r_q_cd[i] - c_CD_W'(1);
        end
      end
      if (w_push) begin
        r_q_id[r_wr_ptr]   <= bus.i_req_id;
        r_q_data[r_wr_ptr] <= w_push_data;
        r_q_cd[r_wr_ptr]   <= c_CD_INIT;
        r_wr_ptr           <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: reference queue/memory model checked every cycle, plus
// directed scenarios with literal expectations.
`default_nettype none

module tb_mem_ctrl;
  localparam int PA = 8, LW = 16, IW = 3, QD = 4, LAT = 3;
`ifdef MEM_CTRL_WRITE_RESP_EN
  localparam bit WRESP = 1'b1;
`else
  localparam bit WRESP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_ctrl_if #(.PA_WIDTH(PA), .LINE_WIDTH(LW), .ID_WIDTH(IW)) bus ();

  mem_ctrl #(.PA_WIDTH(PA), .LINE_WIDTH(LW), .ID_WIDTH(IW),
             .QUEUE_DEPTH(QD), .LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending responses with the cycle they become eligible.
  typedef struct {
    logic [IW-1:0] id;
    logic [LW-1:0] data;
    bit            known;
    int            rdy;
  } ent_t;

  ent_t          mq[$];
  logic [LW-1:0] m_mem   [256];
  bit            m_known [256];
  int            cyc = 0;
  bit            m_push, m_pop, m_wr;
  ent_t          m_ent;
  logic [PA-1:0] m_wa;
  logic [LW-1:0] m_wd;

  initial begin
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;
  end

  always @(negedge clk) begin
    bit   exp_ack, exp_en;
    m_push = 1'b0; m_pop = 1'b0; m_wr = 1'b0;
    if (!rst) begin
      mq.delete();
      chk("rst_req_ack", {31'd0, bus.o_req_ack}, 32'd0);
      chk("rst_resp_en", {31'd0, bus.o_resp_enable}, 32'd0);
      chk("rst_resp_id", {29'd0, bus.o_resp_id}, 32'd0);
      chk("rst_resp_data", {16'd0, bus.o_resp_data}, 32'd0);
    end else begin
      exp_ack = bus.i_req_enable &&
                ((bus.i_req_write && !WRESP) || (mq.size() < QD));
      chk("req_ack", {31'd0, bus.o_req_ack}, {31'd0, exp_ack});
      exp_en = (mq.size() > 0) && (cyc >= mq[0].rdy);
      chk("resp_en", {31'd0, bus.o_resp_enable}, {31'd0, exp_en});
      if (exp_en) begin
        chk("resp_id", {29'd0, bus.o_resp_id}, {29'd0, mq[0].id});
        if (mq[0].known)
          chk("resp_data", {16'd0, bus.o_resp_data}, {16'd0, mq[0].data});
      end
      m_pop  = exp_en && bus.i_resp_ack;
      m_push = exp_ack && (!bus.i_req_write || WRESP);
      m_wr   = exp_ack && bus.i_req_write;
      m_wa   = bus.i_req_addr;
      m_wd   = bus.i_req_data;
      m_ent.id    = bus.i_req_id;
      m_ent.data  = bus.i_req_write ? bus.i_req_data : m_mem[bus.i_req_addr];
      m_ent.known = bus.i_req_write ? 1'b1 : m_known[bus.i_req_addr];
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      mq.delete();
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_push) begin
        m_ent.rdy = cyc + LAT - 1;
        mq.push_back(m_ent);
      end
      if (m_wr) begin
        m_mem[m_wa]   = m_wd;
        m_known[m_wa] = 1'b1;
      end
    end
    m_push = 1'b0; m_pop = 1'b0; m_wr = 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic w, input logic [PA-1:0] a, input logic [LW-1:0] d,
                     input logic [IW-1:0] id);
    int n = 0;
    bus.i_req_enable = 1'b1;
    bus.i_req_write  = w;
    bus.i_req_addr   = a;
    bus.i_req_data   = d;
    bus.i_req_id     = id;
    forever begin
      @(negedge clk);
      if (bus.o_req_ack) break;
      n++;
      if (n > 20) begin
        chk("req_timeout", 32'd0, 32'd1);
        break;
      end
      tick();
    end
    tick();
    bus.i_req_enable = 1'b0;
  endtask

  // Returns at a falling edge where a response is presented, or flags a timeout.
  task automatic wait_resp(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (bus.o_resp_enable) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("resp_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int n);
    bus.i_resp_ack = 1'b1;
    repeat (n) tick();
    bus.i_resp_ack = 1'b0;
  endtask

  initial begin
    bit            ok;
    logic [LW-1:0] got_d[2];
    logic [IW-1:0] got_i[2];
    int            k;

    bus.i_req_enable = 1'b0;
    bus.i_req_write  = 1'b0;
    bus.i_req_addr   = '0;
    bus.i_req_data   = '0;
    bus.i_req_id     = '0;
    bus.i_resp_ack   = 1'b0;
    repeat (2) @(negedge clk);
    tick();
    rst = 1'b1;
    tick();

    // Write then read back with latency 3
    req(1'b1, 8'h02, 16'hAAAA, 3'd1);
    req(1'b0, 8'h02, 16'h0000, 3'd2);
`ifndef MEM_CTRL_WRITE_RESP_EN
    @(negedge clk); chk("lat_cyc1_en", {31'd0, bus.o_resp_enable}, 32'd0); tick();
    @(negedge clk); chk("lat_cyc2_en", {31'd0, bus.o_resp_enable}, 32'd0); tick();
    @(negedge clk); chk("lat_cyc3_en", {31'd0, bus.o_resp_enable}, 32'd1);
    chk("lat_id", {29'd0, bus.o_resp_id}, 32'd2);
    chk("lat_data", {16'd0, bus.o_resp_data}, 32'h0000AAAA);
    tick();
`endif
    drain(6);

    // Fill the queue, then offer a fifth read and a write
    for (int i = 0; i < 4; i++) req(1'b0, 8'h02, 16'h0000, 3'(i));
    bus.i_req_enable = 1'b1; bus.i_req_write = 1'b0;
    bus.i_req_addr = 8'h02; bus.i_req_id = 3'd4;
    repeat (3) begin
      @(negedge clk); chk("full_rd_ack", {31'd0, bus.o_req_ack}, 32'd0); tick();
    end
    bus.i_req_write = 1'b1; bus.i_req_addr = 8'h05;
    bus.i_req_data = 16'h5555; bus.i_req_id = 3'd5;
    @(negedge clk); chk("full_wr_ack", {31'd0, bus.o_req_ack}, WRESP ? 32'd0 : 32'd1);
    tick();
    bus.i_req_write = 1'b0; bus.i_req_addr = 8'h02; bus.i_req_id = 3'd4;
    bus.i_resp_ack = 1'b1;
    @(negedge clk);
    chk("pop_same_cyc_ack", {31'd0, bus.o_req_ack}, 32'd0);
    chk("pop_head_id", {29'd0, bus.o_resp_id}, 32'd0);
    tick();
    bus.i_resp_ack = 1'b0;
    @(negedge clk); chk("after_pop_ack", {31'd0, bus.o_req_ack}, 32'd1);
    tick();
    bus.i_req_enable = 1'b0;

    // Backpressure holds the head stable
    repeat (5) begin
      @(negedge clk);
      chk("bp_en", {31'd0, bus.o_resp_enable}, 32'd1);
      chk("bp_id", {29'd0, bus.o_resp_id}, 32'd1);
      chk("bp_data", {16'd0, bus.o_resp_data}, 32'h0000AAAA);
      tick();
    end
    bus.i_resp_ack = 1'b1;
    tick();
    bus.i_resp_ack = 1'b0;
    @(negedge clk); chk("bp_next_id", {29'd0, bus.o_resp_id}, 32'd2);
    tick();
    drain(8);

    // Read/write/read ordering on one address
    req(1'b1, 8'h04, 16'h0BEE, 3'd0);
    drain(5);
    bus.i_resp_ack = 1'b1;
    req(1'b0, 8'h04, 16'h0000, 3'd1);
    req(1'b1, 8'h04, 16'h1234, 3'd2);
    req(1'b0, 8'h04, 16'h0000, 3'd3);
    k = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (bus.o_resp_enable && k < 2) begin
        got_d[k] = bus.o_resp_data;
        got_i[k] = bus.o_resp_id;
        k++;
      end
      tick();
    end
    bus.i_resp_ack = 1'b0;
`ifndef MEM_CTRL_WRITE_RESP_EN
    chk("raw_count", k, 32'd2);
    chk("raw_id0", {29'd0, got_i[0]}, 32'd1);
    chk("raw_old", {16'd0, got_d[0]}, 32'h00000BEE);
    chk("raw_id1", {29'd0, got_i[1]}, 32'd3);
    chk("raw_new", {16'd0, got_d[1]}, 32'h00001234);
`endif

    // Reset with pending responses
    req(1'b0, 8'h02, 16'h0000, 3'd6);
    req(1'b0, 8'h02, 16'h0000, 3'd7);
    rst = 1'b0;
    #1;
    chk("async_rst_en", {31'd0, bus.o_resp_enable}, 32'd0);
    chk("async_rst_ack", {31'd0, bus.o_req_ack}, 32'd0);
    tick();
    rst = 1'b1;
    bus.i_resp_ack = 1'b1;
    repeat (8) begin
      @(negedge clk); chk("post_rst_en", {31'd0, bus.o_resp_enable}, 32'd0); tick();
    end
    bus.i_resp_ack = 1'b0;
    req(1'b0, 8'h02, 16'h0000, 3'd3);
    wait_resp(ok);
    if (ok) begin
      chk("post_rst_id", {29'd0, bus.o_resp_id}, 32'd3);
      chk("post_rst_data", {16'd0, bus.o_resp_data}, 32'h0000AAAA);
    end
    tick();
    drain(4);

`ifdef MEM_CTRL_WRITE_RESP_EN
    req(1'b1, 8'h04, 16'hCCCC, 3'd5);
    wait_resp(ok);
    if (ok) begin
      chk("wresp_id", {29'd0, bus.o_resp_id}, 32'd5);
      chk("wresp_data", {16'd0, bus.o_resp_data}, 32'h0000CCCC);
    end
    tick();
    drain(4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule

`default_nettype wire
